pkg_write_controller: RTL and testbench

PKG_WRITE_CONTROLLER -- requirements
Module: pkg_write_controller

---
 rtl/pkg_write_controller.sv | 144 ++++++++++++++
 tb/tb_pkg_write_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pkg_write_controller.sv
// Packet write controller: stores incoming packet words into pages of a data RAM,
// taking pages from a free list and chaining them through a link RAM.
//
// state | meaning
// IDLE  | waiting for a free page to open a new packet
// WRITE | accepting packet words into the current page
// ALLOC | current page full, waiting for a free page to chain to
// DONE  | packet complete: self-link tail page, report head/tail/length
module pkg_write_controller #(
  parameter int ADDR_WIDTH        = 12,
  parameter int ADDR_PAGE_NUM_LOG = 6,
  parameter int DATA_WIDTH        = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pkg_valid,
  output logic                         pkg_ready,
  input  logic [DATA_WIDTH-1:0]        pkg_data,
  input  logic                         pkg_last,
  output logic                         empty_table_read_req,
  input  logic [ADDR_PAGE_NUM_LOG-1:0] empty_table_read_addr,
  input  logic                         empty_table_empty,
  output logic                         ram_write_req,
  output logic [ADDR_WIDTH-1:0]        ram_write_addr,
  output logic [DATA_WIDTH-1:0]        ram_write_data,
  output logic                         link_write_req,
  output logic [ADDR_PAGE_NUM_LOG-1:0] link_write_addr,
  output logic [ADDR_PAGE_NUM_LOG-1:0] link_write_data,
  output logic                         pkg_done,
  output logic [ADDR_PAGE_NUM_LOG-1:0] pkg_head_addr,
  output logic [ADDR_PAGE_NUM_LOG-1:0] pkg_tail_addr,
  output logic [ADDR_WIDTH:0]          pkg_length
);

  localparam int OFF_W = ADDR_WIDTH - ADDR_PAGE_NUM_LOG;
  localparam int PG_W  = ADDR_PAGE_NUM_LOG;
  localparam int LEN_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, WRITE, ALLOC, DONE} state_t;

  state_t            state, state_nxt;
  logic [PG_W-1:0]   cur_page, head_page, hold_head, hold_tail;
  logic [OFF_W-1:0]  offset;
  logic [LEN_W-1:0]  length, hold_len;
  logic              free_ok, beat, pop;

  // Strobes are gated by rst_n so nothing fires while reset is held.
  assign free_ok = rst_n && !empty_table_empty;
  assign beat    = (state == WRITE) && pkg_valid;
  assign pop     = ((state == IDLE) || (state == ALLOC)) && free_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_page  <= '0;
      head_page <= '0;
      offset    <= '0;
      length    <= '0;
      hold_head <= '0;
      hold_tail <= '0;
      hold_len  <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        cur_page <= empty_table_read_addr;
        offset   <= '0;
        if (state == IDLE) begin
          head_page <= empty_table_read_addr;
          length    <= '0;
        end
      end
      if (beat) begin
        if (offset != '1) offset <= offset + 1'b1;
        if (length != '1) length <= length + 1'b1;
      end
      if (state == DONE) begin
        hold_head <= head_page;
        hold_tail <= cur_page;
        hold_len  <= length;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (free_ok) state_nxt = WRITE;
      WRITE: begin
        if (beat) begin
          if (pkg_last)           state_nxt = DONE;
          else if (offset == '1)  state_nxt = ALLOC;
        end
      end
      ALLOC:   if (free_ok) state_nxt = WRITE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pkg_ready            = 1'b0;
    empty_table_read_req = 1'b0;
    ram_write_req        = 1'b0;
    ram_write_addr       = '0;
    ram_write_data       = '0;
    link_write_req       = 1'b0;
    link_write_addr      = '0;
    link_write_data      = '0;
    pkg_done             = 1'b0;
    pkg_head_addr        = hold_head;
    pkg_tail_addr        = hold_tail;
    pkg_length           = hold_len;
    case (state)
      IDLE: empty_table_read_req = free_ok;
      WRITE: begin
        pkg_ready = 1'b1;
        if (pkg_valid) begin
          ram_write_req  = 1'b1;
          ram_write_addr = {cur_page, offset};
          ram_write_data = pkg_data;
        end
      end
      ALLOC: begin
        if (free_ok) begin
          empty_table_read_req = 1'b1;
          link_write_req       = 1'b1;
          link_write_addr      = cur_page;
          link_write_data      = empty_table_read_addr;
        end
      end
      DONE: begin
        link_write_req  = 1'b1;
        link_write_addr = cur_page;
        link_write_data = cur_page;
        pkg_done        = 1'b1;
        pkg_head_addr   = head_page;
        pkg_tail_addr   = cur_page;
        pkg_length      = length;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pkg_write_controller.sv
// Directed bench for pkg_write_controller with 4-word pages and 16 pages.
module tb_pkg_write_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pkg_valid, pkg_ready, pkg_last;
  logic [7:0] pkg_data;
  logic       empty_table_read_req, empty_table_empty;
  logic [3:0] empty_table_read_addr;
  logic       ram_write_req;
  logic [5:0] ram_write_addr;
  logic [7:0] ram_write_data;
  logic       link_write_req;
  logic [3:0] link_write_addr, link_write_data;
  logic       pkg_done;
  logic [3:0] pkg_head_addr, pkg_tail_addr;
  logic [6:0] pkg_length;

  pkg_write_controller #(.ADDR_WIDTH(6), .ADDR_PAGE_NUM_LOG(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .pkg_valid(pkg_valid), .pkg_ready(pkg_ready), .pkg_data(pkg_data), .pkg_last(pkg_last),
    .empty_table_read_req(empty_table_read_req), .empty_table_read_addr(empty_table_read_addr),
    .empty_table_empty(empty_table_empty),
    .ram_write_req(ram_write_req), .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data),
    .link_write_req(link_write_req), .link_write_addr(link_write_addr), .link_write_data(link_write_data),
    .pkg_done(pkg_done), .pkg_head_addr(pkg_head_addr), .pkg_tail_addr(pkg_tail_addr),
    .pkg_length(pkg_length)
  );

  always #5 clk = ~clk;

  // Free-list model: head is combinational, popped on each read_req edge.
  logic [3:0] free_mem [256];
  int         fl_rd = 0;
  int         fl_wr = 0;
  logic       stall = 1'b0;
  assign empty_table_empty     = stall || (fl_rd >= fl_wr);
  assign empty_table_read_addr = free_mem[fl_rd[7:0]];
  always @(posedge clk) if (empty_table_read_req) fl_rd <= fl_rd + 1;

  logic [5:0] wr_a[$];
  logic [7:0] wr_d[$];
  logic [3:0] lk_a[$];
  logic [3:0] lk_d[$];
  int         done_cnt = 0;
  int         bad_pop = 0;
  int         stall_rdy = 0;
  logic [3:0] d_head, d_tail;
  logic [6:0] d_len;

  always @(negedge clk) begin
    if (stall && wr_a.size() >= 4 && pkg_ready) stall_rdy++;
    if (empty_table_read_req && empty_table_empty) bad_pop++;
    if (ram_write_req) begin wr_a.push_back(ram_write_addr); wr_d.push_back(ram_write_data); end
    if (link_write_req) begin lk_a.push_back(link_write_addr); lk_d.push_back(link_write_data); end
    if (pkg_done) begin
      done_cnt++;
      d_head = pkg_head_addr; d_tail = pkg_tail_addr; d_len = pkg_length;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    int         npg;
    logic [3:0] pg[3];
    int         nw;
    bit         tog;
    int         st;
    logic [5:0] wa[9];
    int         nl;
    logic [3:0] la[3];
    logic [3:0] ld[3];
    logic [3:0] head;
    logic [3:0] tail;
    logic [6:0] len;
  } vec_t;

  vec_t vt[7];

  task automatic clear_q();
    wr_a.delete(); wr_d.delete(); lk_a.delete(); lk_d.delete();
  endtask

  // Called and returns at posedge+1.
  task automatic send_pkt(input int n_total, input int n_send, input bit tog, input int st,
                          input logic [7:0] base);
    int i = 0; int cyc = 0; int sl = 0; bit ph = 1'b1; bit b; bit st_done = 1'b0;
    while (i < n_send && cyc < 400) begin
      if (st > 0 && i == st - 1 && !st_done) begin stall = 1'b1; sl = 10; st_done = 1'b1; end
      pkg_valid = tog ? ph : 1'b1;
      pkg_data  = base + 8'(i);
      pkg_last  = (i == n_total - 1);
      @(negedge clk);
      b = pkg_valid && pkg_ready;
      @(posedge clk); #1;
      if (b) i++;
      ph = !ph;
      cyc++;
      if (sl > 0) begin sl--; if (sl == 0) stall = 1'b0; end
    end
    pkg_valid = 1'b0; pkg_last = 1'b0; stall = 1'b0;
    check("send_beats", 0, i, n_send);
  endtask

  task automatic wait_done(input int d0);
    for (int c = 0; c < 30 && done_cnt == d0; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int k, input bit load);
    int d0; int n; logic [7:0] base;
    base = 8'(16 * k + 3);
    clear_q();
    if (load) for (int j = 0; j < v.npg; j++) begin free_mem[fl_wr] = v.pg[j]; fl_wr++; end
    d0 = done_cnt;
    send_pkt(v.nw, v.nw, v.tog, v.st, base);
    wait_done(d0);
    check("wr_count", k, wr_a.size(), v.nw);
    n = (wr_a.size() < v.nw) ? wr_a.size() : v.nw;
    for (int j = 0; j < n; j++) begin
      check("wr_addr", k * 16 + j, wr_a[j], v.wa[j]);
      check("wr_data", k * 16 + j, wr_d[j], base + 8'(j));
    end
    check("link_count", k, lk_a.size(), v.nl);
    n = (lk_a.size() < v.nl) ? lk_a.size() : v.nl;
    for (int j = 0; j < n; j++) begin
      check("link_addr", k * 16 + j, lk_a[j], v.la[j]);
      check("link_data", k * 16 + j, lk_d[j], v.ld[j]);
    end
    check("done_pulses", k, done_cnt - d0, 1);
    check("done_head", k, d_head, v.head);
    check("done_tail", k, d_tail, v.tail);
    check("done_len", k, d_len, v.len);
    check("pages_popped", k, fl_rd, fl_wr);
    @(negedge clk);
    check("hold_head", k, pkg_head_addr, v.head);
    check("hold_tail", k, pkg_tail_addr, v.tail);
    check("hold_len", k, pkg_length, v.len);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t post;
    int   d0;

    vt[0] = '{1, '{4'd5, 4'd0, 4'd0}, 3, 1'b0, 0,
              '{6'h14, 6'h15, 6'h16, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0},
              1, '{4'd5, 4'd0, 4'd0}, '{4'd5, 4'd0, 4'd0}, 4'd5, 4'd5, 7'd3};
    vt[1] = '{2, '{4'd2, 4'd7, 4'd0}, 5, 1'b0, 0,
              '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h1C, 6'h0, 6'h0, 6'h0, 6'h0},
              2, '{4'd2, 4'd7, 4'd0}, '{4'd7, 4'd7, 4'd0}, 4'd2, 4'd7, 7'd5};
    vt[2] = '{1, '{4'd3, 4'd0, 4'd0}, 4, 1'b0, 0,
              '{6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0},
              1, '{4'd3, 4'd0, 4'd0}, '{4'd3, 4'd0, 4'd0}, 4'd3, 4'd3, 7'd4};
    vt[3] = '{1, '{4'd9, 4'd0, 4'd0}, 3, 1'b1, 0,
              '{6'h24, 6'h25, 6'h26, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0},
              1, '{4'd9, 4'd0, 4'd0}, '{4'd9, 4'd0, 4'd0}, 4'd9, 4'd9, 7'd3};
    vt[4] = '{3, '{4'd1, 4'd4, 4'd15}, 9, 1'b0, 0,
              '{6'h04, 6'h05, 6'h06, 6'h07, 6'h10, 6'h11, 6'h12, 6'h13, 6'h3C},
              3, '{4'd1, 4'd4, 4'd15}, '{4'd4, 4'd15, 4'd15}, 4'd1, 4'd15, 7'd9};
    vt[5] = '{1, '{4'd14, 4'd0, 4'd0}, 1, 1'b0, 0,
              '{6'h38, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0},
              1, '{4'd14, 4'd0, 4'd0}, '{4'd14, 4'd0, 4'd0}, 4'd14, 4'd14, 7'd1};
    vt[6] = '{2, '{4'd10, 4'd11, 4'd0}, 8, 1'b0, 4,
              '{6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D, 6'h2E, 6'h2F, 6'h0},
              2, '{4'd10, 4'd11, 4'd0}, '{4'd11, 4'd11, 4'd0}, 4'd10, 4'd11, 7'd8};

    rst_n = 1'b0; pkg_valid = 1'b0; pkg_data = 8'h0; pkg_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 0, pkg_ready, 0);
    check("rst_read_req", 0, empty_table_read_req, 0);
    check("rst_ram_req", 0, ram_write_req, 0);
    check("rst_link_req", 0, link_write_req, 0);
    check("rst_done", 0, pkg_done, 0);
    check("rst_head", 0, pkg_head_addr, 0);
    check("rst_tail", 0, pkg_tail_addr, 0);
    check("rst_len", 0, pkg_length, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    for (int k = 0; k < 7; k++) run_vec(vt[k], k, 1'b1);
    check("stall_ready", 0, stall_rdy, 0);

    // Reset two beats into a packet, with a free page still available.
    clear_q();
    free_mem[fl_wr] = 4'd6; fl_wr++;
    free_mem[fl_wr] = 4'd8; fl_wr++;
    d0 = done_cnt;
    send_pkt(5, 2, 1'b0, 0, 8'h70);
    pkg_valid = 1'b1; pkg_data = 8'h72; rst_n = 1'b0;
    @(negedge clk);
    check("mrst_ready", 0, pkg_ready, 0);
    check("mrst_read_req", 0, empty_table_read_req, 0);
    check("mrst_ram_req", 0, ram_write_req, 0);
    check("mrst_ram_addr", 0, ram_write_addr, 0);
    check("mrst_ram_data", 0, ram_write_data, 0);
    check("mrst_link_req", 0, link_write_req, 0);
    check("mrst_link_addr", 0, link_write_addr, 0);
    check("mrst_link_data", 0, link_write_data, 0);
    check("mrst_done", 0, pkg_done, 0);
    check("mrst_head", 0, pkg_head_addr, 0);
    check("mrst_tail", 0, pkg_tail_addr, 0);
    check("mrst_len", 0, pkg_length, 0);
    @(posedge clk); #1;
    pkg_valid = 1'b0; rst_n = 1'b1;
    check("abort_writes", 0, wr_a.size(), 2);
    check("abort_links", 0, lk_a.size(), 0);
    check("abort_done", 0, done_cnt - d0, 0);

    post = '{0, '{4'd0, 4'd0, 4'd0}, 2, 1'b0, 0,
             '{6'h20, 6'h21, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0},
             1, '{4'd8, 4'd0, 4'd0}, '{4'd8, 4'd0, 4'd0}, 4'd8, 4'd8, 7'd2};
    run_vec(post, 7, 1'b0);

    // 130 words over 33 pages: length must stop at 127.
    clear_q();
    for (int j = 0; j < 33; j++) begin free_mem[fl_wr] = 4'(j % 16); fl_wr++; end
    d0 = done_cnt;
    send_pkt(130, 130, 1'b0, 0, 8'h00);
    wait_done(d0);
    check("sat_done", 0, done_cnt - d0, 1);
    check("sat_len", 0, d_len, 7'd127);
    check("sat_head", 0, d_head, 4'd0);
    check("sat_tail", 0, d_tail, 4'd0);
    check("sat_writes", 0, wr_a.size(), 130);
    if (wr_a.size() > 0) check("sat_last_addr", 0, wr_a[wr_a.size() - 1], 6'h01);
    check("sat_links", 0, lk_a.size(), 33);
    if (lk_a.size() > 31) check("sat_link31", 0, {lk_a[31], lk_d[31]}, {4'd15, 4'd0});

    check("bad_pops", 0, bad_pop, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
